// File: rtl/mem_port_arb_pkg.sv
// Shared definitions for the SISC memory-port arbiter.
//   state_t : FSM state encodings (IDLE / ACCESS / DONE)
//   owner_t : owner of the access in flight (fetch or data)
//   CNT_W   : width of the wait-state down-counter
package sisc_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_t;

    localparam int CNT_W = 4;

endpackage

// File: rtl/mem_port_arb_if.sv
// Bus bundle between the requesters, the arbiter and the memory.
//   if_*   : instruction-fetch request, address, read data, done pulse
//   dm_*   : load/store request, we, address, write data, read data, done
//   mem_*  : memory strobe, write enable, address, write/read data
//   busy   : arbiter not idle; owner : 0 = fetch, 1 = data
// Modports: slave = arbiter view, master = requester/memory view.
interface mem_port_arb_if #(
    parameter int AW = 16,
    parameter int DW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_done;

    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic [DW-1:0] dm_rdata;
    logic          dm_done;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic          busy;
    logic          owner;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_rdata, if_done, dm_rdata, dm_done,
               mem_en, mem_we, mem_addr, mem_wdata, busy, owner
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_rdata, if_done, dm_rdata, dm_done,
               mem_en, mem_we, mem_addr, mem_wdata, busy, owner
    );

endinterface

// File: rtl/mem_port_arb_lat_counter.sv
// Loadable 4-bit down-counter timing the wait states of one access.
//   clk, rst_f : clock, async active-low reset
//   load       : load load_val (has priority over dec)
//   load_val   : value to load
//   dec        : decrement by one, stopping at zero
//   zero       : counter equals zero (terminal count)
module lat_counter
    import sisc_mem_pkg::*;
(
    input  logic             clk,
    input  logic             rst_f,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign zero = (r_cnt == '0);

endmodule

// File: rtl/mem_port_arb.sv
// Two-requester arbiter/sequencer for the single-ported SISC memory.
// Data requests beat fetches unless the fetch has been passed over
// STARVE_MAX consecutive times. Each access holds mem_en for MEM_LAT
// cycles, then pulses the owner's done with registered read data.
//   clk, rst_f : clock, async active-low reset
//   bus        : mem_port_arb_if slave modport (requesters + memory)
//
//   state     | meaning
//   ----------+------------------------------------------------------
//   ST_IDLE   | no access in flight; grant a pending request
//   ST_ACCESS | mem_en high, wait states counting down
//   ST_DONE   | done pulse to owner; always back to IDLE
module mem_port_arb
    import sisc_mem_pkg::*;
#(
    parameter int AW         = 16,
    parameter int DW         = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 3
) (
    input  logic           clk,
    input  logic           rst_f,
    mem_port_arb_if.slave  bus
);

    localparam int               SW       = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT - 1);

    state_t        r_state;
    state_t        w_next_state;
    owner_t        r_owner;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_if_rdata;
    logic [DW-1:0] r_dm_rdata;
    logic [SW-1:0] r_starve;

    logic          w_win_dm;
    logic          w_load;
    logic          w_dec;
    logic          w_zero;
    logic          w_capture;
    logic          w_mem_en;
    logic          w_if_done;
    logic          w_dm_done;

    // Fetch overrides data priority only once it has been passed over
    // STARVE_MAX times in a row while actually waiting.
    assign w_win_dm = bus.dm_req &&
                      !(bus.if_req && (r_starve == SW'(STARVE_MAX)));

    lat_counter u_lat_counter (
        .clk      (clk),
        .rst_f    (rst_f),
        .load     (w_load),
        .load_val (LAT_LOAD),
        .dec      (w_dec),
        .zero     (w_zero)
    );

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_dec        = 1'b0;
        w_capture    = 1'b0;
        w_mem_en     = 1'b0;
        w_if_done    = 1'b0;
        w_dm_done    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.if_req || bus.dm_req) begin
                    w_load       = 1'b1;
                    w_next_state = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                w_mem_en = 1'b1;
                w_dec    = 1'b1;
                if (w_zero) begin
                    w_capture    = 1'b1;
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                w_if_done    = (r_owner == OWN_IF);
                w_dm_done    = (r_owner == OWN_DM);
                w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Request latch, starvation counter and read-data capture.
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            r_owner    <= OWN_IF;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_if_rdata <= '0;
            r_dm_rdata <= '0;
            r_starve   <= '0;
        end else begin
            if (w_load) begin
                if (w_win_dm) begin
                    r_owner <= OWN_DM;
                    r_addr  <= bus.dm_addr;
                    r_we    <= bus.dm_we;
                    r_wdata <= bus.dm_wdata;
                    if (bus.if_req && (r_starve != SW'(STARVE_MAX))) begin
                        r_starve <= r_starve + SW'(1);
                    end
                end else begin
                    r_owner  <= OWN_IF;
                    r_addr   <= bus.if_addr;
                    r_we     <= 1'b0;
                    r_starve <= '0;
                end
            end
            if (w_capture && !r_we) begin
                if (r_owner == OWN_DM) begin
                    r_dm_rdata <= bus.mem_rdata;
                end else begin
                    r_if_rdata <= bus.mem_rdata;
                end
            end
        end
    end

    assign bus.mem_en    = w_mem_en;
    assign bus.mem_we    = w_mem_en & r_we;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.dm_rdata  = r_dm_rdata;
    assign bus.if_done   = w_if_done;
    assign bus.dm_done   = w_dm_done;
    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.owner     = r_owner;

endmodule
